// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and the
// baud divider computation used by both the receive and transmit paths.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam int DATA_BITS      = 8;
    localparam int OVERSAMPLE_DEF = 16;

    // Clocks per oversample tick; clamped to 1 so a fast baud never yields a zero divider.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        int div;
        div = clk_freq / (baud * oversample);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-clock tick every DIV clocks, where DIV is
// the number of system clocks per oversample period.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, regardless of the order the always_ff blocks are evaluated in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF input synchronizer, 16x oversampled mid-bit sampling,
// start-glitch rejection, stop-bit framing check and break handling.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

    logic tick;

    logic [1:0]           sync_q;
    logic                 rx_s;
    rx_state_e            state_q,     state_d;
    logic [3:0]           tick_cnt_q,  tick_cnt_d;
    logic [2:0]           bit_cnt_q,   bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rx_done_q,   rx_done_d;
    logic                 wait_high_q, wait_high_d;

    baud_tick_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // wait_high_q blocks arming until the line has been seen idle, covering both
    // a break after a framing error and a line that is low when reset releases.
    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                ST_IDLE:  if (!rx_s && !wait_high_q) state_d = ST_START;
                ST_START: if (tick_cnt_q == TICK_MID) state_d = rx_s ? ST_IDLE : ST_DATA;
                ST_DATA:  if (tick_cnt_q == TICK_LAST && bit_cnt_q == BIT_LAST) state_d = ST_STOP;
                ST_STOP:  if (tick_cnt_q == TICK_LAST) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: every variable assigned in an always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        rx_busy     = (state_q != ST_IDLE);
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        frame_err_d = frame_err_q;
        wait_high_d = wait_high_q;
        rx_done_d   = 1'b0;
        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    if (rx_s) wait_high_d = 1'b0;
                end
                ST_START: begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
                ST_DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        if (bit_cnt_q != BIT_LAST) bit_cnt_d = bit_cnt_q + 3'd1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
                ST_STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        rx_data_d   = shift_q;
                        frame_err_d = ~rx_s;
                        wait_high_d = ~rx_s;
                        rx_done_d   = 1'b1;
                        tick_cnt_d  = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
                default: tick_cnt_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            frame_err_q <= 1'b0;
            rx_done_q   <= 1'b0;
            wait_high_q <= 1'b1;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            frame_err_q <= frame_err_d;
            rx_done_q   <= rx_done_d;
            wait_high_q <= wait_high_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core at a fast baud (one tick per clock, 16 clocks per bit).
module tb_uart_rx_core;

    localparam int CLK_FREQ = 100_000_000;
    localparam int BAUD     = 6_250_000;
    localparam int BIT_CLKS = CLK_FREQ / BAUD;
    localparam int STOP_MIN = BIT_CLKS / 2 + 4;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;
    int   n_sent   = 0;
    int   base;
    logic prev_done = 1'b0;

    uart_rx_core #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; drives one 8N1 frame and queues its expected result.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int stop_clks);
        exp_q.push_back('{data: d, ferr: ~stop_bit});
        n_sent++;
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = stop_bit;
        repeat (stop_clks) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst && rx_done) begin
            n_done++;
            check("done_width", prev_done, 1'b0);
            check("done_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("rx_data", rx_data, mon_e.data);
                check("frame_err", frame_err, mon_e.ferr);
            end
        end
        prev_done = rx_done;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_done", rx_done, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_rx_busy", rx_busy, 1'b0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Basic frames with a full stop bit.
        send_frame(8'h30, 1'b1, BIT_CLKS);
        send_frame(8'h31, 1'b1, BIT_CLKS);
        send_frame(8'h32, 1'b1, BIT_CLKS);
        send_frame(8'h6E, 1'b1, BIT_CLKS);
        repeat (BIT_CLKS) @(negedge clk);
        check("t1_done_cnt", n_done, 4);
        check("t1_hold_rx_data", rx_data, 8'h6E);

        // Back-to-back with stop held only just past its midpoint.
        send_frame(8'hA5, 1'b1, STOP_MIN);
        send_frame(8'h5A, 1'b1, BIT_CLKS);
        check("t2_done_cnt", n_done, 6);

        // Start glitch shorter than half a bit.
        base = n_done;
        rx = 1'b0;
        repeat (BIT_CLKS / 4) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check("t3_glitch_busy", rx_busy, 1'b1);
        repeat (BIT_CLKS) @(negedge clk);
        check("t3_glitch_idle", rx_busy, 1'b0);
        check("t3_no_done", n_done, base);

        // Framing error with the line held low afterwards, then a good frame.
        send_frame(8'h55, 1'b0, 2 * BIT_CLKS);
        check("t4_ferr_set", frame_err, 1'b1);
        check("t4_err_data", rx_data, 8'h55);
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        send_frame(8'h0F, 1'b1, BIT_CLKS);
        check("t4_ferr_clear", frame_err, 1'b0);

        // Reset in the middle of data bit 4 of 8'hFF.
        base = n_done;
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        check("t5_busy_pre", rx_busy, 1'b1);
        rst = 1'b0;
        #1;
        check("t5_rst_rx_data", rx_data, 8'h00);
        check("t5_rst_rx_done", rx_done, 1'b0);
        check("t5_rst_frame_err", frame_err, 1'b0);
        check("t5_rst_rx_busy", rx_busy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4 * BIT_CLKS) @(negedge clk);
        send_frame(8'h3C, 1'b1, BIT_CLKS);
        check("t5_done_cnt", n_done, base + 1);
        check("t5_rx_data", rx_data, 8'h3C);

        // Random back-to-back stream.
        base = n_done;
        repeat (256) send_frame(8'($urandom_range(255)), 1'b1, STOP_MIN);
        for (int i = 0; i < 4 * BIT_CLKS && exp_q.size() != 0; i++) @(negedge clk);
        check("t6_sb_drained", exp_q.size(), 0);
        check("t6_done_cnt", n_done - base, 256);
        check("total_done", n_done, n_sent);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
